// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file.
//   - CSR address map
//   - bit positions inside mstatus / mie / mip
//   - write masks for the WARL registers
//   - csr_op_t encoding of the read-modify-write operation
//   - csr_rmw(): computes the value a RW/RS/RC operation would write
package csr_pkg;

  // Machine information registers (read as zero)
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // Machine trap setup / handling
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;

  // Counter halves. Counter index i sits at offset 0 (mcycle) or i+1
  // (minstret = 2, mhpmcounter3.. = 3..), leaving the time slot at 1 empty.
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
  localparam logic [11:0] CSR_MHPMH_BASE    = 12'hB83;

  // mstatus fields
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // mie / mip fields
  localparam int MI_MSI_BIT = 3;
  localparam int MI_MTI_BIT = 7;
  localparam int MI_MEI_BIT = 11;

  // WARL write masks
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    RW   = 2'b01,
    RS   = 2'b10,
    RC   = 2'b11
  } csr_op_t;

  function automatic logic [31:0] csr_rmw(input csr_op_t op,
                                          input logic [31:0] old_value,
                                          input logic [31:0] operand);
    logic [31:0] result;
    case (op)
      RW:      result = operand;
      RS:      result = old_value | operand;
      RC:      result = old_value & ~operand;
      default: result = old_value;
    endcase
    return result;
  endfunction

  // mtvec keeps mode 0 (direct) and 1 (vectored); reserved modes become 0.
  function automatic logic [31:0] warl_mtvec(input logic [31:0] value);
    return {value[31:2], (value[1:0] == 2'b01) ? 2'b01 : 2'b00};
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit event counter with CSR-writable halves.
//   clk, reset         clock, asynchronous active-high reset (clears count)
//   inc                count request for this cycle
//   inhibit            suppresses inc
//   write_lo/write_hi  load wdata into the low/high half; the increment is
//                      skipped that cycle and the other half is held
//   wdata              load value
//   value              current 64-bit count
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        write_lo,
  input  logic        write_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (write_lo) begin
      count_reg[31:0] <= wdata;
    end else if (write_hi) begin
      count_reg[63:32] <= wdata;
    end else if (inc && !inhibit) begin
      // All-ones wraps naturally to zero.
      count_reg <= count_reg + 64'd1;
    end
  end

  assign value = count_reg;

endmodule

// File: rtl/csr_file_hpm.sv
// csr_file_hpm: machine-mode CSR file with RW/RS/RC operations, WARL
// masking, trap entry / MRET stacking, sampled interrupt pending bits,
// vectored trap targets and 64-bit cycle/instret/HPM counters.
//   clk, reset            clock, asynchronous active-high reset
//   CSR_RADR_SD           decode-stage read address
//   CSR_RDATA_SC          read data (combinational, pre-update value)
//   CSR_ILLEGAL_SC        set when CSR_RADR_SD selects no register
//   CSR_ENABLE_SM/OP_SM/WADR_SM/WDATA_SM   memory-stage CSR commit
//   EXCEPTION_SM + MCAUSE/MEPC/MTVAL_WDATA_SM   trap entry
//   MRET_SM               return from trap
//   INSTR_RETIRED_SM      minstret event
//   HPM_EVENT_SM          per-counter HPM events
//   IRQ_EXT/TIMER/SW      level interrupt lines (sampled into mip)
//   MSTATUS_RC .. MCAUSE_SC   register values
//   TRAP_TARGET_SC        next PC for a trap taken this cycle
//   IRQ_PENDING_SC        enabled interrupt pending
module csr_file_hpm
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          NUM_HPM     = 4,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     CSR_RADR_SD,
  output logic [XLEN-1:0] CSR_RDATA_SC,
  output logic            CSR_ILLEGAL_SC,
  input  logic            CSR_ENABLE_SM,
  input  logic [1:0]      CSR_OP_SM,
  input  logic [11:0]     CSR_WADR_SM,
  input  logic [XLEN-1:0] CSR_WDATA_SM,
  input  logic            EXCEPTION_SM,
  input  logic [XLEN-1:0] MCAUSE_WDATA_SM,
  input  logic [XLEN-1:0] MEPC_WDATA_SM,
  input  logic [XLEN-1:0] MTVAL_WDATA_SM,
  input  logic            MRET_SM,
  input  logic            INSTR_RETIRED_SM,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] HPM_EVENT_SM,
  input  logic            IRQ_EXT,
  input  logic            IRQ_TIMER,
  input  logic            IRQ_SW,
  output logic [XLEN-1:0] MSTATUS_RC,
  output logic [XLEN-1:0] MIE_VALUE_RC,
  output logic [XLEN-1:0] MIP_VALUE_RC,
  output logic [XLEN-1:0] MTVEC_VALUE_RC,
  output logic [XLEN-1:0] MEPC_SC,
  output logic [XLEN-1:0] MCAUSE_SC,
  output logic [XLEN-1:0] TRAP_TARGET_SC,
  output logic            IRQ_PENDING_SC
);

  // mcycle, minstret, then the HPM counters
  localparam int NUM_CNT = 2 + NUM_HPM;

  // Inhibit bits exist for mcycle (0), minstret (2) and each HPM counter.
  localparam logic [31:0] MCOUNTINHIBIT_WMASK =
      32'(((64'd1 << NUM_HPM) - 64'd1) << 3) | 32'h0000_0005;

  // ---------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------
  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic [31:0] mie_reg;
  logic [31:0] mip_reg;
  logic [31:0] mip_next;
  logic [31:0] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;
  logic [31:0] mcountinhibit_reg;

  logic [63:0]        cnt_value [NUM_CNT];
  logic [NUM_CNT-1:0] cnt_inc;
  logic [NUM_CNT-1:0] cnt_write_lo;
  logic [NUM_CNT-1:0] cnt_write_hi;

  logic [31:0] mstatus_value;

  // MPP is hard-wired to machine mode.
  assign mstatus_value = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg, 3'd0,
                          mstatus_mie_reg, 3'd0};

  // ---------------------------------------------------------------------
  // Address lookup, instantiated twice: port 0 serves the decode-stage
  // read, port 1 fetches the old value for the memory-stage RMW.
  // ---------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_lookup
    logic [11:0] adr;
    logic [31:0] data;
    logic        legal;

    assign adr = (gi == 0) ? CSR_RADR_SD : CSR_WADR_SM;

    always_comb begin
      data  = '0;
      legal = 1'b1;
      case (adr)
        CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: data = '0;
        CSR_MSTATUS:       data = mstatus_value;
        CSR_MISA:          data = MISA_VALUE;
        CSR_MIE:           data = mie_reg;
        CSR_MTVEC:         data = mtvec_reg;
        CSR_MSTATUSH:      data = '0;
        CSR_MCOUNTINHIBIT: data = mcountinhibit_reg;
        CSR_MSCRATCH:      data = mscratch_reg;
        CSR_MEPC:          data = mepc_reg;
        CSR_MCAUSE:        data = mcause_reg;
        CSR_MTVAL:         data = mtval_reg;
        CSR_MIP:           data = mip_reg;
        default: begin
          legal = 1'b0;
          for (int i = 0; i < NUM_CNT; i++) begin
            if (adr == CSR_MCYCLE + 12'((i == 0) ? 0 : i + 1)) begin
              data  = cnt_value[i][31:0];
              legal = 1'b1;
            end
            if (adr == CSR_MCYCLEH + 12'((i == 0) ? 0 : i + 1)) begin
              data  = cnt_value[i][63:32];
              legal = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign CSR_RDATA_SC   = g_lookup[0].data;
  assign CSR_ILLEGAL_SC = !g_lookup[0].legal;

  // ---------------------------------------------------------------------
  // Write qualification
  // ---------------------------------------------------------------------
  csr_op_t     op;
  logic        set_clear_zero;
  logic        write_req;
  logic [31:0] wr_new;

  assign op             = csr_op_t'(CSR_OP_SM);
  assign set_clear_zero = ((op == RS) || (op == RC)) && (CSR_WDATA_SM == '0);
  assign wr_new         = csr_rmw(op, g_lookup[1].data, CSR_WDATA_SM);

  // Trap entry and MRET own the cycle; read-only space, misa, mstatush and
  // unimplemented addresses swallow the write.
  assign write_req = CSR_ENABLE_SM && (op != NONE) && !set_clear_zero &&
                     !EXCEPTION_SM && !MRET_SM &&
                     (CSR_WADR_SM[11:10] != 2'b11) && g_lookup[1].legal &&
                     (CSR_WADR_SM != CSR_MISA) && (CSR_WADR_SM != CSR_MSTATUSH);

  // ---------------------------------------------------------------------
  // Interrupt sampling
  // ---------------------------------------------------------------------
  always_comb begin
    mip_next             = '0;
    mip_next[MI_MSI_BIT] = IRQ_SW;
    mip_next[MI_MTI_BIT] = IRQ_TIMER;
    mip_next[MI_MEI_BIT] = IRQ_EXT;
  end

  // ---------------------------------------------------------------------
  // Register updates: trap entry > MRET > CSR write
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie_reg   <= 1'b0;
      mstatus_mpie_reg  <= 1'b0;
      mie_reg           <= '0;
      mip_reg           <= '0;
      mtvec_reg         <= MTVEC_RESET;
      mscratch_reg      <= '0;
      mepc_reg          <= '0;
      mcause_reg        <= '0;
      mtval_reg         <= '0;
      mcountinhibit_reg <= '0;
    end else begin
      mip_reg <= mip_next;
      if (EXCEPTION_SM) begin
        mepc_reg         <= MEPC_WDATA_SM & MEPC_WMASK;
        mcause_reg       <= MCAUSE_WDATA_SM;
        mtval_reg        <= MTVAL_WDATA_SM;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (MRET_SM) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (write_req) begin
        case (CSR_WADR_SM)
          CSR_MSTATUS: begin
            mstatus_mie_reg  <= wr_new[MSTATUS_MIE_BIT];
            mstatus_mpie_reg <= wr_new[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:           mie_reg           <= wr_new & MIE_WMASK;
          CSR_MTVEC:         mtvec_reg         <= warl_mtvec(wr_new);
          CSR_MCOUNTINHIBIT: mcountinhibit_reg <= wr_new & MCOUNTINHIBIT_WMASK;
          CSR_MSCRATCH:      mscratch_reg      <= wr_new;
          CSR_MEPC:          mepc_reg          <= wr_new & MEPC_WMASK;
          CSR_MCAUSE:        mcause_reg        <= wr_new;
          CSR_MTVAL:         mtval_reg         <= wr_new;
          default: ;  // mip is read-only; counters load inside csr_counter64
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------
  for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    // Address offset and mcountinhibit bit share the same numbering.
    localparam int OFF = (gi == 0) ? 0 : gi + 1;

    if (gi == 0) begin : g_cycle
      assign cnt_inc[gi] = 1'b1;
    end else if (gi == 1) begin : g_instret
      assign cnt_inc[gi] = INSTR_RETIRED_SM;
    end else begin : g_hpm
      assign cnt_inc[gi] = HPM_EVENT_SM[gi-2];
    end

    assign cnt_write_lo[gi] = write_req && (CSR_WADR_SM == CSR_MCYCLE + 12'(OFF));
    assign cnt_write_hi[gi] = write_req && (CSR_WADR_SM == CSR_MCYCLEH + 12'(OFF));

    csr_counter64 u_counter (
      .clk      (clk),
      .reset    (reset),
      .inc      (cnt_inc[gi]),
      .inhibit  (mcountinhibit_reg[OFF]),
      .write_lo (cnt_write_lo[gi]),
      .write_hi (cnt_write_hi[gi]),
      .wdata    (CSR_WDATA_SM),
      .value    (cnt_value[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Trap target and interrupt summary
  // ---------------------------------------------------------------------
  logic [31:0] mtvec_base;
  assign mtvec_base = {mtvec_reg[31:2], 2'b00};

  always_comb begin
    TRAP_TARGET_SC = mtvec_base;
    // Only interrupts (cause MSB set) are vectored.
    if ((mtvec_reg[1:0] == 2'b01) && MCAUSE_WDATA_SM[31]) begin
      TRAP_TARGET_SC = mtvec_base + {25'd0, MCAUSE_WDATA_SM[4:0], 2'b00};
    end
  end

  assign IRQ_PENDING_SC = mstatus_mie_reg && |(mip_reg & mie_reg);

  assign MSTATUS_RC     = mstatus_value;
  assign MIE_VALUE_RC   = mie_reg;
  assign MIP_VALUE_RC   = mip_reg;
  assign MTVEC_VALUE_RC = mtvec_reg;
  assign MEPC_SC        = mepc_reg;
  assign MCAUSE_SC      = mcause_reg;

endmodule

// File: tb/tb_csr_file_hpm.sv
// tb_csr_file_hpm: directed vectors and hand-written sequences for
// csr_file_hpm (default parameters).
module tb_csr_file_hpm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] CSR_RADR_SD = '0;
  logic [31:0] CSR_RDATA_SC;
  logic        CSR_ILLEGAL_SC;
  logic        CSR_ENABLE_SM = 1'b0;
  logic [1:0]  CSR_OP_SM = 2'b00;
  logic [11:0] CSR_WADR_SM = '0;
  logic [31:0] CSR_WDATA_SM = '0;
  logic        EXCEPTION_SM = 1'b0;
  logic [31:0] MCAUSE_WDATA_SM = '0;
  logic [31:0] MEPC_WDATA_SM = '0;
  logic [31:0] MTVAL_WDATA_SM = '0;
  logic        MRET_SM = 1'b0;
  logic        INSTR_RETIRED_SM = 1'b0;
  logic [3:0]  HPM_EVENT_SM = '0;
  logic        IRQ_EXT = 1'b0;
  logic        IRQ_TIMER = 1'b0;
  logic        IRQ_SW = 1'b0;
  logic [31:0] MSTATUS_RC, MIE_VALUE_RC, MIP_VALUE_RC, MTVEC_VALUE_RC;
  logic [31:0] MEPC_SC, MCAUSE_SC, TRAP_TARGET_SC;
  logic        IRQ_PENDING_SC;

  int errors = 0;
  int checks = 0;

  csr_file_hpm dut (
    .clk              (clk),
    .reset            (reset),
    .CSR_RADR_SD      (CSR_RADR_SD),
    .CSR_RDATA_SC     (CSR_RDATA_SC),
    .CSR_ILLEGAL_SC   (CSR_ILLEGAL_SC),
    .CSR_ENABLE_SM    (CSR_ENABLE_SM),
    .CSR_OP_SM        (CSR_OP_SM),
    .CSR_WADR_SM      (CSR_WADR_SM),
    .CSR_WDATA_SM     (CSR_WDATA_SM),
    .EXCEPTION_SM     (EXCEPTION_SM),
    .MCAUSE_WDATA_SM  (MCAUSE_WDATA_SM),
    .MEPC_WDATA_SM    (MEPC_WDATA_SM),
    .MTVAL_WDATA_SM   (MTVAL_WDATA_SM),
    .MRET_SM          (MRET_SM),
    .INSTR_RETIRED_SM (INSTR_RETIRED_SM),
    .HPM_EVENT_SM     (HPM_EVENT_SM),
    .IRQ_EXT          (IRQ_EXT),
    .IRQ_TIMER        (IRQ_TIMER),
    .IRQ_SW           (IRQ_SW),
    .MSTATUS_RC       (MSTATUS_RC),
    .MIE_VALUE_RC     (MIE_VALUE_RC),
    .MIP_VALUE_RC     (MIP_VALUE_RC),
    .MTVEC_VALUE_RC   (MTVEC_VALUE_RC),
    .MEPC_SC          (MEPC_SC),
    .MCAUSE_SC        (MCAUSE_SC),
    .TRAP_TARGET_SC   (TRAP_TARGET_SC),
    .IRQ_PENDING_SC   (IRQ_PENDING_SC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] wadr;
    logic [31:0] wdata;
    logic [11:0] radr;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [11:0] adr,
                            input logic [31:0] exp);
    CSR_RADR_SD = adr;
    #1;
    check(name, CSR_RDATA_SC, exp);
    $display("read %03h -> %08h (expect %08h)", adr, CSR_RDATA_SC, exp);
  endtask

  task automatic csr_write(input logic [1:0] op, input logic [11:0] adr,
                           input logic [31:0] data);
    CSR_ENABLE_SM = 1'b1;
    CSR_OP_SM     = op;
    CSR_WADR_SM   = adr;
    CSR_WDATA_SM  = data;
    step();
    CSR_ENABLE_SM = 1'b0;
    CSR_OP_SM     = 2'b00;
    $display("write op=%0d adr=%03h data=%08h", op, adr, data);
  endtask

  initial begin
    // op, wadr, wdata, radr, expected rdata, expected illegal
    vecs[0]  = '{2'b01, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 1'b0};
    vecs[1]  = '{2'b10, 12'h300, 32'h0000_0008, 12'h300, 32'h0000_1808, 1'b0};
    vecs[2]  = '{2'b11, 12'h300, 32'h0000_0008, 12'h300, 32'h0000_1800, 1'b0};
    vecs[3]  = '{2'b01, 12'h340, 32'hA5A5_A5A5, 12'h340, 32'hA5A5_A5A5, 1'b0};
    vecs[4]  = '{2'b10, 12'h340, 32'h0000_0000, 12'h340, 32'hA5A5_A5A5, 1'b0};
    vecs[5]  = '{2'b11, 12'h340, 32'h0000_FFFF, 12'h340, 32'hA5A5_0000, 1'b0};
    vecs[6]  = '{2'b01, 12'h305, 32'h0000_0103, 12'h305, 32'h0000_0100, 1'b0};
    vecs[7]  = '{2'b01, 12'h305, 32'h0000_0101, 12'h305, 32'h0000_0101, 1'b0};
    vecs[8]  = '{2'b01, 12'h341, 32'h0000_2003, 12'h341, 32'h0000_2000, 1'b0};
    vecs[9]  = '{2'b01, 12'h301, 32'h0000_0000, 12'h301, 32'h4000_0100, 1'b0};
    vecs[10] = '{2'b01, 12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0000_0000, 1'b0};
    vecs[11] = '{2'b01, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 1'b0};
    vecs[12] = '{2'b01, 12'h300, 32'h0000_0000, 12'h300, 32'h0000_1800, 1'b0};
    vecs[13] = '{2'b01, 12'h342, 32'h8000_0007, 12'h342, 32'h8000_0007, 1'b0};
    vecs[14] = '{2'b01, 12'h320, 32'hFFFF_FFFF, 12'h320, 32'h0000_007D, 1'b0};
    vecs[15] = '{2'b01, 12'h320, 32'h0000_0000, 12'h320, 32'h0000_0000, 1'b0};
    vecs[16] = '{2'b01, 12'h7C0, 32'h1234_5678, 12'h7C0, 32'h0000_0000, 1'b1};
    vecs[17] = '{2'b01, 12'hF11, 32'h0000_0001, 12'hF11, 32'h0000_0000, 1'b0};
    vecs[18] = '{2'b01, 12'h310, 32'hFFFF_FFFF, 12'h310, 32'h0000_0000, 1'b0};
    vecs[19] = '{2'b11, 12'h304, 32'h0000_0000, 12'h304, 32'h0000_0888, 1'b0};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    read_check("rst_mstatus", 12'h300, 32'h0000_1800);
    read_check("rst_mcycle_held", 12'hB00, 32'h0);
    check("rst_mtvec", MTVEC_VALUE_RC, 32'h0);
    check("rst_irq_pending", {31'd0, IRQ_PENDING_SC}, 32'h0);
    reset = 1'b0;
    read_check("rst_misa", 12'h301, 32'h4000_0100);
    read_check("mcycle_t0", 12'hB00, 32'd0);
    step();
    read_check("mcycle_t1", 12'hB00, 32'd1);
    step();
    read_check("mcycle_t2", 12'hB00, 32'd2);

    // ---- table-driven CSR operations ----
    for (int i = 0; i < 20; i++) begin
      csr_write(vecs[i].op, vecs[i].wadr, vecs[i].wdata);
      CSR_RADR_SD = vecs[i].radr;
      #1;
      check($sformatf("vec%0d_data", i), CSR_RDATA_SC, vecs[i].exp_data);
      check($sformatf("vec%0d_ill", i), {31'd0, CSR_ILLEGAL_SC},
            {31'd0, vecs[i].exp_ill});
      $display("vec %0d op=%0d wadr=%03h wdata=%08h radr=%03h rdata=%08h ill=%0d",
               i, vecs[i].op, vecs[i].wadr, vecs[i].wdata, vecs[i].radr,
               CSR_RDATA_SC, CSR_ILLEGAL_SC);
    end

    // ---- trap entry with a simultaneous (dropped) CSR write ----
    csr_write(2'b10, 12'h300, 32'h8);          // MIE=1, mtvec is 0x101
    EXCEPTION_SM    = 1'b1;
    MEPC_WDATA_SM   = 32'h0000_1003;
    MTVAL_WDATA_SM  = 32'h0000_0055;
    MCAUSE_WDATA_SM = 32'h0000_000B;
    CSR_ENABLE_SM   = 1'b1;
    CSR_OP_SM       = 2'b01;
    CSR_WADR_SM     = 12'h340;
    CSR_WDATA_SM    = 32'h1234_5678;
    #1;
    check("trap_target_exc", TRAP_TARGET_SC, 32'h0000_0100);
    MCAUSE_WDATA_SM = 32'h8000_000B;
    #1;
    check("trap_target_irq", TRAP_TARGET_SC, 32'h0000_012C);
    step();
    EXCEPTION_SM  = 1'b0;
    CSR_ENABLE_SM = 1'b0;
    #1;
    check("trap_mepc", MEPC_SC, 32'h0000_1000);
    check("trap_mcause", MCAUSE_SC, 32'h8000_000B);
    check("trap_mstatus", MSTATUS_RC, 32'h0000_1880);
    read_check("trap_mscratch_kept", 12'h340, 32'hA5A5_0000);
    read_check("trap_mtval", 12'h343, 32'h0000_0055);
    $display("trap: mepc=%08h mcause=%08h mstatus=%08h", MEPC_SC, MCAUSE_SC, MSTATUS_RC);

    // ---- MRET with a simultaneous (dropped) mstatus write ----
    MRET_SM       = 1'b1;
    CSR_ENABLE_SM = 1'b1;
    CSR_OP_SM     = 2'b01;
    CSR_WADR_SM   = 12'h300;
    CSR_WDATA_SM  = 32'h0;
    step();
    MRET_SM       = 1'b0;
    CSR_ENABLE_SM = 1'b0;
    #1;
    check("mret_mstatus", MSTATUS_RC, 32'h0000_1888);
    $display("mret: mstatus=%08h", MSTATUS_RC);

    // ---- 64-bit wrap ----
    csr_write(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_write(2'b01, 12'hB80, 32'hFFFF_FFFF);
    read_check("wrap_pre_hi", 12'hB80, 32'hFFFF_FFFF);
    read_check("wrap_pre_lo", 12'hB00, 32'hFFFF_FFFF);
    step();
    read_check("wrap_lo", 12'hB00, 32'h0);
    read_check("wrap_hi", 12'hB80, 32'h0);

    // ---- minstret inhibit ----
    csr_write(2'b01, 12'h320, 32'h4);
    INSTR_RETIRED_SM = 1'b1;
    repeat (5) step();
    read_check("instret_inhibited", 12'hB02, 32'd0);
    csr_write(2'b01, 12'h320, 32'h0);
    repeat (5) step();
    INSTR_RETIRED_SM = 1'b0;
    read_check("instret_counted", 12'hB02, 32'd5);

    // ---- HPM event counter 1 (mhpmcounter4) ----
    repeat (3) begin
      HPM_EVENT_SM = 4'b0010;
      step();
      HPM_EVENT_SM = 4'b0000;
      step();
    end
    read_check("hpm1_count", 12'hB04, 32'd3);
    read_check("hpm0_idle", 12'hB03, 32'd0);

    // ---- interrupt sampling (mstatus.MIE is 1 after MRET) ----
    csr_write(2'b01, 12'h304, 32'h80);
    IRQ_TIMER = 1'b1;
    #1;
    check("mip_before", MIP_VALUE_RC, 32'h0);
    check("pending_before", {31'd0, IRQ_PENDING_SC}, 32'h0);
    step();
    check("mip_after", MIP_VALUE_RC, 32'h80);
    check("pending_after", {31'd0, IRQ_PENDING_SC}, 32'h1);
    $display("irq: mip=%08h pending=%0d", MIP_VALUE_RC, IRQ_PENDING_SC);

    // ---- address decode boundaries ----
    read_check("illegal_7c0", 12'h7C0, 32'h0);
    check("illegal_7c0_flag", {31'd0, CSR_ILLEGAL_SC}, 32'h1);
    CSR_RADR_SD = 12'hB06;
    #1;
    check("hpm_last_legal", {31'd0, CSR_ILLEGAL_SC}, 32'h0);
    CSR_RADR_SD = 12'hB07;
    #1;
    check("hpm_past_end_illegal", {31'd0, CSR_ILLEGAL_SC}, 32'h1);
    $display("decode: B07 illegal=%0d", CSR_ILLEGAL_SC);

    // ---- asynchronous reset mid-cycle ----
    step();
    reset = 1'b1;
    #1;
    check("arst_mstatus", MSTATUS_RC, 32'h0000_1800);
    check("arst_mepc", MEPC_SC, 32'h0);
    check("arst_mie", MIE_VALUE_RC, 32'h0);
    check("arst_mip", MIP_VALUE_RC, 32'h0);
    read_check("arst_mcycle", 12'hB00, 32'h0);
    reset = 1'b0;
    $display("async reset: mstatus=%08h", MSTATUS_RC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_file_hpm.md
Name: csr_file_hpm

Overview:
Parametrised machine-mode CSR file, successor to the basic CSR register bank. It adds CSRRW/CSRRS/CSRRC read-modify-write operations, WARL field masking, and trap-entry/MRET stacking of mstatus. It also adds sampled interrupt-pending bits, vectored trap targets, and 64-bit cycle, instret and NUM_HPM event counters with mcountinhibit. Sits beside the memory stage: decode reads, memory stage commits writes/traps.

Parameters:
XLEN, 32, data width (only 32 supported; counters split lo/hi)
NUM_HPM, 4, number of mhpmcounter3..(3+NUM_HPM-1), range 0..29
MISA_VALUE, 32'h40000100, read-only misa contents
MTVEC_RESET, 32'h0, mtvec reset value

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
CSR_RADR_SD  in  12  read address
CSR_RDATA_SC  out  XLEN  read data, combinational
CSR_ILLEGAL_SC  out  1  CSR_RADR_SD not implemented
CSR_ENABLE_SM  in  1  commit CSR op this cycle
CSR_OP_SM  in  2  01 RW, 10 RS, 11 RC, 00 no-op
CSR_WADR_SM  in  12  write address
CSR_WDATA_SM  in  XLEN  operand (rs1/uimm)
EXCEPTION_SM  in  1  trap entry this cycle
MCAUSE_WDATA_SM / MEPC_WDATA_SM / MTVAL_WDATA_SM  in  XLEN each  trap values
MRET_SM  in  1  MRET commit
INSTR_RETIRED_SM  in  1  one instruction retired
HPM_EVENT_SM  in  NUM_HPM  per-counter event strobes
IRQ_EXT / IRQ_TIMER / IRQ_SW  in  1 each  level interrupt lines
MSTATUS_RC, MIE_VALUE_RC, MIP_VALUE_RC, MTVEC_VALUE_RC, MEPC_SC, MCAUSE_SC  out  XLEN each  register values
TRAP_TARGET_SC  out  XLEN  next-PC for a trap, combinational
IRQ_PENDING_SC  out  1  mstatus.MIE & |(mip & mie)

Behaviour:
- Reset: mstatus=32'h1800 (MPP=11), mie/mip/mepc/mcause/mtval/mscratch/mcountinhibit/all counters=0, mtvec=MTVEC_RESET. All outputs follow from these values.
- Addresses: F11-F14 read 0. 300 mstatus, 301 misa, 304 mie, 305 mtvec, 310 mstatush (reads 0), 320 mcountinhibit, 340-344 mscratch/mepc/mcause/mtval/mip.
- Counter addresses: B00/B80 mcycle lo/hi, B02/B82 minstret, B03+k/B83+k hpm k.
- Any other read address -> RDATA=0, ILLEGAL=1.
- Write data: RW->op; RS->old|op; RC->old&~op. RS/RC with op==0 perform no write. Writes to addr[11:10]==11, misa, mstatush, or unimplemented addresses are ignored.
- WARL masks:
  - mstatus: only bits 3 (MIE) and 7 (MPIE) writable; MPP reads 11.
  - mie: bits 3,7,11 only.
  - mip: not writable; bits 3/7/11 = IRQ_SW/TIMER/EXT registered each cycle (1-cycle latency).
  - mtvec: mode[1:0] values 2/3 stored as 0.
  - mepc: bits[1:0] forced 0.
  - mcountinhibit: bits 0, 2, 3..3+NUM_HPM-1 only.
- Priority within a cycle: EXCEPTION_SM > MRET_SM > CSR write.
  - EXCEPTION_SM: mepc/mcause/mtval loaded; MPIE<=MIE, MIE<=0.
  - MRET_SM: MIE<=MPIE, MPIE<=1.
  - A CSR write in the same cycle as EXCEPTION_SM or MRET_SM is dropped.
- Counters:
  - mcycle +1 every cycle unless inhibit[0].
  - minstret +1 on INSTR_RETIRED_SM unless inhibit[2].
  - hpm k +1 on HPM_EVENT_SM[k] unless inhibit[3+k].
  - 64-bit wrap FFFF_FFFF_FFFF_FFFF -> 0.
  - A CSR write to a counter half loads that half; the whole counter skips its increment that cycle (other half held).
- Reads return the pre-update register value (no write bypass).
- TRAP_TARGET_SC: mtvec mode 0 -> {base,00}. Mode 1 and MCAUSE_WDATA_SM[31]=1 -> base + 4*MCAUSE_WDATA_SM[4:0]; otherwise base.
- Reset asserted mid-operation returns all state to reset values immediately.

Decomposition:
- csr_pkg holds:
  - CSR address localparams
  - mstatus/mip/mie bit indices
  - WARL write masks
  - csr_op_t enum {NONE, RW, RS, RC}
- Sub-module csr_counter64: 64-bit counter with inc, inhibit, write_lo, write_hi, wdata; instantiated 2+NUM_HPM times via generate.

Test Plan:
- Reset release -> read 300 = 32'h1800, 301 = MISA_VALUE, B00 increments by 1 per cycle thereafter.
- RW 304 32'hFFFFFFFF -> read 0x00000888; RS 300 32'h8 -> MIE set; RC 300 32'h8 -> cleared; RS 340 op=0 -> mscratch unchanged.
- MIE=1, EXCEPTION_SM with mcause 32'h8000000B, mepc 32'h1003, mtvec 32'h101 -> mepc=32'h1000, MSTATUS MIE=0/MPIE=1, TRAP_TARGET=32'h12C. Then MRET_SM -> MIE=1, MPIE=1.
- Write B00=32'hFFFFFFFF, B80=32'hFFFFFFFF on consecutive cycles -> following cycle counter reads 0/0 (wrap).
- mcountinhibit=32'h4, INSTR_RETIRED_SM held 5 cycles -> minstret unchanged; clear inhibit -> +5 over 5 cycles. HPM_EVENT_SM[1] pulses 3x -> B04=3.
- IRQ_TIMER=1, mie=32'h80, MIE=1 -> mip bit 7 and IRQ_PENDING_SC rise one cycle later. EXCEPTION_SM with simultaneous RW 340 -> mscratch unchanged. Read 0x7C0 -> ILLEGAL=1, RDATA=0.
